// File: rtl/mult_issue_ctrl.sv
// Issue front-end for the shift-add multiplier: operand FIFO, issue FSM, result hold.
// Optional ZERO_BYPASS_EN: pairs with a zero operand skip the multiplier.
module mult_issue_ctrl #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic           mul_init,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  output logic [W-1:0]   mul_n,
  input  logic           mul_finish,
  input  logic [2*W-1:0] mul_p,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_p,
  output logic           busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, HOLD
  } state_e;

  state_e state_q, state_d;

  logic [W-1:0]   mem_a_q [DEPTH];
  logic [W-1:0]   mem_b_q [DEPTH];
  logic [AW-1:0]  wptr_q, rptr_q;
  logic [AW:0]    cnt_q;
  logic           push, pop, empty;
  logic [W-1:0]   head_a, head_b;

  logic [W-1:0]   mul_a_q, mul_a_d;
  logic [W-1:0]   mul_b_q, mul_b_d;
  logic [2*W-1:0] out_p_q, out_p_d;
  logic           out_valid_q, out_valid_d;
  logic           init;

  // in_ready depends only on the count register
  assign in_ready = (cnt_q != (AW+1)'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign push     = in_valid & in_ready;
  assign head_a   = mem_a_q[rptr_q];
  assign head_b   = mem_b_q[rptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a_q[wptr_q] <= in_a;
      mem_b_q[wptr_q] <= in_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (push && !pop)
        cnt_q <= cnt_q + 1'b1;
      else if (pop && !push)
        cnt_q <= cnt_q - 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    init        = 1'b0;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    out_p_d     = out_p_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          mul_a_d = head_a;
          mul_b_d = head_b;
`ifdef ZERO_BYPASS_EN
          if (head_a == '0 || head_b == '0) begin
            state_d     = HOLD;
            out_p_d     = '0;
            out_valid_d = 1'b1;
          end else begin
            state_d = ISSUE;
          end
`else
          state_d = ISSUE;
`endif
        end
      end
      ISSUE: begin
        init    = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (mul_finish) begin
          out_p_d     = mul_p;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      out_p_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      out_p_q     <= out_p_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign mul_init  = init;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign mul_n     = W'(W);
  assign out_p     = out_p_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Directed bench for mult_issue_ctrl with a behavioural multiplier model.
// Build with +define+ZERO_BYPASS_EN to check the bypass variant.
module tb_mult_issue_ctrl;
  localparam int W = 8;
  localparam int DEPTH = 4;

  logic clk = 0;
  logic rst_n;
  logic in_valid;
  logic in_ready;
  logic [W-1:0] in_a, in_b;
  logic mul_init;
  logic [W-1:0] mul_a, mul_b, mul_n;
  logic mul_finish;
  logic [2*W-1:0] mul_p;
  logic out_valid;
  logic out_ready;
  logic [2*W-1:0] out_p;
  logic busy;

  logic model_fin, stray_fin;
  logic [2*W-1:0] model_p;
  int init_cnt = 0;
  int total = 0;
  int bad = 0;

  assign mul_finish = model_fin | stray_fin;
  assign mul_p = stray_fin ? 16'hDEAD : model_p;

  always #5 clk = ~clk;

  mult_issue_ctrl #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .mul_init(mul_init), .mul_a(mul_a),
    .mul_b(mul_b), .mul_n(mul_n),
    .mul_finish(mul_finish), .mul_p(mul_p),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .busy(busy)
  );

  always @(negedge clk) if (mul_init) init_cnt <= init_cnt + 1;

  // multiplier model: finish 2 cycles after the init pulse
  initial begin
    logic [2*W-1:0] la, lb;
    model_fin = 0;
    model_p = 0;
    forever begin
      @(negedge clk);
      if (mul_init) begin
        la = {8'd0, mul_a};
        lb = {8'd0, mul_b};
        repeat (2) @(posedge clk);
        #1 model_fin = 1;
        model_p = la * lb;
        @(posedge clk);
        #1 model_fin = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] a,
                      input logic [W-1:0] b,
                      output bit acc);
    acc = in_ready;
    in_valid = 1;
    in_a = a;
    in_b = b;
    step();
    in_valid = 0;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s timeout out_valid=%b want 1", nm, out_valid);
    end
  endtask

  task automatic test_reset();
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready);
    end
    total++;
    if ({mul_init, out_valid, busy} !== 3'b000) begin
      bad++;
      $display("FAIL rst_flags got=%b want=000",
               {mul_init, out_valid, busy});
    end
    total++;
    if (mul_a !== 0 || mul_b !== 0) begin
      bad++; $display("FAIL rst_ops got=%0d,%0d want=0,0", mul_a, mul_b);
    end
    total++;
    if (out_p !== 0) begin
      bad++; $display("FAIL rst_out_p got=%0d want=0", out_p);
    end
    total++;
    if (mul_n !== 8) begin
      bad++; $display("FAIL mul_n got=%0d want=8", mul_n);
    end
  endtask

  task automatic test_basic();
    bit acc;
    int base = init_cnt;
    out_ready = 1;
    push(13, 11, acc);
    wait_valid("basic");
    total++;
    if (out_p !== 16'd143) begin
      bad++; $display("FAIL basic_p got=%0d want=143", out_p);
    end
    total++;
    if (init_cnt - base !== 1) begin
      bad++; $display("FAIL basic_inits got=%0d want=1", init_cnt - base);
    end
    total++;
    if (mul_a !== 13 || mul_b !== 11) begin
      bad++; $display("FAIL basic_ops got=%0d,%0d want=13,11", mul_a, mul_b);
    end
    step();
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_one_cycle got=%b%b want=00", out_valid, busy);
    end
  endtask

  task automatic test_full_width();
    bit acc;
    out_ready = 1;
    push(255, 255, acc);
    wait_valid("wide");
    total++;
    if (out_p !== 16'hFE01) begin
      bad++; $display("FAIL wide_p got=%0h want=fe01", out_p);
    end
    step();
  endtask

  task automatic test_back_to_back();
    bit acc;
    int nacc = 0;
    int base = init_cnt;
    logic [W-1:0] v;
    out_ready = 0;
    for (int i = 1; i <= 6; i++) begin
      v = W'(i);
      push(v, v, acc);
      if (acc) nacc++;
      if (i == 6) begin
        total++;
        if (acc !== 1'b0) begin
          bad++; $display("FAIL b2b_sixth_ready got=%b want=0", acc);
        end
      end
    end
    total++;
    if (nacc !== 5) begin
      bad++; $display("FAIL b2b_accepted got=%0d want=5", nacc);
    end
    wait_valid("b2b_first");
    repeat (10) step();
    total++;
    if (out_valid !== 1 || out_p !== 1) begin
      bad++; $display("FAIL b2b_hold got=%b/%0d want=1/1", out_valid, out_p);
    end
    total++;
    if (init_cnt - base !== 1) begin
      bad++; $display("FAIL b2b_inits got=%0d want=1", init_cnt - base);
    end
    out_ready = 1;
    for (int k = 1; k <= 5; k++) begin
      wait_valid("b2b_res");
      total++;
      if (out_p !== 16'(k * k)) begin
        bad++; $display("FAIL b2b_order got=%0d want=%0d", out_p, k * k);
      end
      step();
    end
    step();
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL b2b_idle busy=%b want=0", busy);
    end
  endtask

  task automatic test_hold();
    bit acc;
    int nbad = 0;
    int base = init_cnt;
    out_ready = 0;
    push(7, 9, acc);
    wait_valid("hold");
    for (int c = 0; c < 20; c++) begin
      if (c == 5 || c == 12) stray_fin = 1;
      step();
      stray_fin = 0;
      if (out_valid !== 1 || out_p !== 16'd63) nbad++;
    end
    total++;
    if (nbad != 0) begin
      bad++; $display("FAIL hold_stable bad_cycles=%0d want=0", nbad);
    end
    total++;
    if (init_cnt - base !== 1) begin
      bad++; $display("FAIL hold_inits got=%0d want=1", init_cnt - base);
    end
    out_ready = 1;
    step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL hold_release got=%b want=0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    bit acc;
    int nbad = 0;
    out_ready = 1;
    push(3, 5, acc);
    step();
    step();
    rst_n = 0;
    #2;
    total++;
    if ({in_ready, out_valid, busy, mul_init} !== 4'b1000) begin
      bad++;
      $display("FAIL midrst_flags got=%b want=1000",
               {in_ready, out_valid, busy, mul_init});
    end
    total++;
    if (mul_a !== 0 || mul_b !== 0 || out_p !== 0) begin
      bad++;
      $display("FAIL midrst_regs got=%0d,%0d,%0d want=0,0,0",
               mul_a, mul_b, out_p);
    end
    #2 rst_n = 1;
    for (int c = 0; c < 6; c++) begin
      step();
      if (out_valid !== 0 || busy !== 0) nbad++;
    end
    stray_fin = 1;
    step();
    stray_fin = 0;
    step();
    if (out_valid !== 0 || busy !== 0) nbad++;
    total++;
    if (nbad != 0) begin
      bad++; $display("FAIL midrst_finish_ignored bad=%0d want=0", nbad);
    end
  endtask

  task automatic test_zero();
    bit acc;
    int base = init_cnt;
    out_ready = 1;
    push(0, 77, acc);
`ifdef ZERO_BYPASS_EN
    step();
    total++;
    if (out_valid !== 1'b1 || out_p !== 0) begin
      bad++;
      $display("FAIL zero_bypass got=%b/%0d want=1/0", out_valid, out_p);
    end
    total++;
    if (mul_a !== 0 || mul_b !== 77) begin
      bad++; $display("FAIL zero_ops got=%0d,%0d want=0,77", mul_a, mul_b);
    end
    total++;
    if (init_cnt - base !== 0) begin
      bad++; $display("FAIL zero_inits got=%0d want=0", init_cnt - base);
    end
`else
    wait_valid("zero");
    total++;
    if (out_p !== 0) begin
      bad++; $display("FAIL zero_p got=%0d want=0", out_p);
    end
    total++;
    if (init_cnt - base !== 1) begin
      bad++; $display("FAIL zero_inits got=%0d want=1", init_cnt - base);
    end
`endif
    step();
    step();
  endtask

  initial begin
    rst_n = 0;
    in_valid = 0;
    in_a = 0;
    in_b = 0;
    out_ready = 0;
    stray_fin = 0;
    repeat (2) step();
    rst_n = 1;
    step();
    test_reset();
    test_basic();
    test_full_width();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    test_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
